// File: rtl/fetch_queue.sv
// fetch_queue: issues imem reads for the sequential PC stream and queues in-order {pc, instr} pairs for decode.
// Latency: a response in cycle N is visible on dec_* in cycle N+1; flush drops in-flight responses via a drop counter.
// Backpressure: pc_ready_o low once DEPTH entries are allocated; FETCH_QUEUE_PERF_EN adds stall/drop counters.
module fetch_queue #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      pc_i,
  input  logic             pc_valid_i,
  output logic             pc_ready_o,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [31:0]      imem_rdata_i,
  output logic             dec_valid_o,
  output logic [31:0]      dec_pc_o,
  output logic [31:0]      dec_instr_o,
  input  logic             dec_ready_i,
  input  logic             flush_i,
  output logic [PTR_W:0]   count_o
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]      stall_cnt_o,
  output logic [15:0]      drop_cnt_o
`endif
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] fill_ptr_q, fill_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W:0]   out_q, out_d;
  logic [PTR_W+1:0] drop_q, drop_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [31:0]      pc_q [DEPTH];
  logic [31:0]      pc_d [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      instr_d [DEPTH];

  logic alloc, pop, fill, drop_rsp, rsp_known;

  // Requests are gated by reset so nothing leaks upstream while rst_ni is low.
  assign imem_req_o  = rst_ni && pc_valid_i && (count_q < FULL_CNT) && !flush_i;
  assign imem_addr_o = {pc_i[31:2], 2'b00};
  assign pc_ready_o  = imem_req_o && imem_gnt_i;
  assign dec_valid_o = filled_q[rd_ptr_q];
  assign dec_pc_o    = pc_q[rd_ptr_q];
  assign dec_instr_o = instr_q[rd_ptr_q];
  assign count_o     = count_q;

  assign alloc     = pc_ready_o;
  assign pop       = dec_valid_o && dec_ready_i;
  assign rsp_known = imem_rvalid_i && ((drop_q != '0) || (out_q != '0));
  assign fill      = imem_rvalid_i && (drop_q == '0) && (out_q != '0);
  assign drop_rsp  = imem_rvalid_i && (drop_q != '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    fill_ptr_d = fill_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    out_d      = out_q;
    drop_d     = drop_q;
    filled_d   = filled_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    if (flush_i) begin
      // Everything still unfilled becomes a response to discard; a coincident response is one of them.
      wr_ptr_d   = '0;
      fill_ptr_d = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      out_d      = '0;
      filled_d   = '0;
      drop_d     = drop_q + {1'b0, out_q} - {{(PTR_W+1){1'b0}}, rsp_known};
    end else begin
      if (alloc) begin
        pc_d[wr_ptr_q]     = pc_i;
        filled_d[wr_ptr_q] = 1'b0;
        wr_ptr_d           = wr_ptr_q + PTR_ONE;
      end
      if (fill) begin
        instr_d[fill_ptr_q]  = imem_rdata_i;
        filled_d[fill_ptr_q] = 1'b1;
        fill_ptr_d           = fill_ptr_q + PTR_ONE;
      end
      if (drop_rsp) begin
        drop_d = drop_q - {{(PTR_W+1){1'b0}}, 1'b1};
      end
      if (pop) begin
        filled_d[rd_ptr_q] = 1'b0;
        rd_ptr_d           = rd_ptr_q + PTR_ONE;
      end
      count_d = count_q + {{PTR_W{1'b0}}, alloc} - {{PTR_W{1'b0}}, pop};
      out_d   = out_q + {{PTR_W{1'b0}}, alloc} - {{PTR_W{1'b0}}, fill};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      filled_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_ptr_q <= fill_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      filled_q   <= filled_d;
    end
  end

  // Payload is qualified by filled_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    pc_q    <= pc_d;
    instr_q <= instr_d;
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        discard;

  assign discard = flush_i ? rsp_known : drop_rsp;

  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'(dec_ready_i && !dec_valid_o);
    drop_cnt_d  = drop_cnt_q;
    if (discard && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus for fetch_queue, checked every cycle against a queue-level model.
// Latency: inputs change 1ns after the rising edge, outputs are compared on the falling edge.
// Backpressure: stall, flush and reset scenarios are driven explicitly through dec_ready_i/flush_i/rst_ni.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        dec_valid_o;
  logic [31:0] dec_pc_o;
  logic [31:0] dec_instr_o;
  logic        dec_ready_i;
  logic        flush_i;
  logic [2:0]  count_o;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .dec_valid_o(dec_valid_o), .dec_pc_o(dec_pc_o), .dec_instr_o(dec_instr_o),
    .dec_ready_i(dec_ready_i), .flush_i(flush_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Model: in-order list of allocated entries; the first nf of them hold data.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t mq[$];
  ent_t tmp;
  int   nf = 0;
  int   drop = 0;
  int   outst;
  logic e_req, e_dv;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      mq.delete();
      nf = 0;
      drop = 0;
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk("rst_pc_ready", 32'(pc_ready_o), 32'd0);
      chk("rst_dec_valid", 32'(dec_valid_o), 32'd0);
      chk("rst_count", 32'(count_o), 32'd0);
    end else begin
      e_req = pc_valid_i && (mq.size() < DEPTH) && !flush_i;
      e_dv  = (nf > 0);
      chk("req", 32'(imem_req_o), 32'(e_req));
      chk("pc_ready", 32'(pc_ready_o), 32'(e_req && imem_gnt_i));
      chk("addr", imem_addr_o, pc_i & 32'hFFFF_FFFC);
      chk("dec_valid", 32'(dec_valid_o), 32'(e_dv));
      chk("count", 32'(count_o), 32'(mq.size()));
      if (e_dv) begin
        chk("dec_pc", dec_pc_o, mq[0].pc);
        chk("dec_instr", dec_instr_o, mq[0].instr);
      end
      outst = mq.size() - nf;
      if (flush_i) begin
        if (imem_rvalid_i && (drop > 0 || outst > 0)) drop = drop + outst - 1;
        else drop = drop + outst;
        mq.delete();
        nf = 0;
      end else begin
        if (imem_rvalid_i) begin
          if (drop > 0) drop--;
          else if (outst > 0) begin
            tmp = mq[nf];
            tmp.instr = imem_rdata_i;
            mq[nf] = tmp;
            nf++;
          end
        end
        if (e_dv && dec_ready_i) begin
          void'(mq.pop_front());
          nf--;
        end
        if (e_req && imem_gnt_i) begin
          tmp.pc = pc_i;
          tmp.instr = 32'h0;
          mq.push_back(tmp);
        end
      end
    end
  end

  task automatic cyc(input logic pv, input logic [31:0] pc, input logic g,
                     input logic rv, input logic [31:0] rd, input logic dr, input logic fl);
    @(posedge clk_i);
    #1;
    pc_valid_i = pv; pc_i = pc; imem_gnt_i = g;
    imem_rvalid_i = rv; imem_rdata_i = rd; dec_ready_i = dr; flush_i = fl;
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  logic [2:0] maxc;

  initial begin
    rst_ni = 1'b1;
    pc_valid_i = 1'b1; pc_i = 32'h10; imem_gnt_i = 1'b1;
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; dec_ready_i = 1'b0; flush_i = 1'b0;
    #1 rst_ni = 1'b0;
    #2;
    chk("init_req", 32'(imem_req_o), 32'd0);
    chk("init_pc_ready", 32'(pc_ready_o), 32'd0);
    chk("init_count", 32'(count_o), 32'd0);
    chk("init_dec_valid", 32'(dec_valid_o), 32'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1; pc_valid_i = 1'b0;

    // Stream 0,4,8,12 with immediate responses and decode always ready.
    maxc = 0;
    cyc(1, 32'h0,  1, 0, 32'h0,         1, 0); if (count_o > maxc) maxc = count_o;
    cyc(1, 32'h4,  1, 1, 32'hA000_0000, 1, 0); if (count_o > maxc) maxc = count_o;
    cyc(1, 32'h8,  1, 1, 32'hA000_0001, 1, 0); if (count_o > maxc) maxc = count_o;
    chk("stream_pc0", dec_pc_o, 32'h0);
    chk("stream_instr0", dec_instr_o, 32'hA000_0000);
    cyc(1, 32'hC,  1, 1, 32'hA000_0002, 1, 0); if (count_o > maxc) maxc = count_o;
    chk("stream_pc1", dec_pc_o, 32'h4);
    cyc(0, 32'h0,  0, 1, 32'hA000_0003, 1, 0); if (count_o > maxc) maxc = count_o;
    cyc(0, 32'h0,  0, 0, 32'h0,         1, 0); if (count_o > maxc) maxc = count_o;
    chk("stream_pc3", dec_pc_o, 32'hC);
    chk("stream_instr3", dec_instr_o, 32'hA000_0003);
    idle(1);
    chk("stream_empty", 32'(dec_valid_o), 32'd0);
    chk("stream_max_count", 32'(maxc), 32'd2);

    // Unaligned PC without grant: address aligned, nothing consumed.
    cyc(1, 32'h70B, 0, 0, 32'h0, 1, 0);
    chk("align_addr", imem_addr_o, 32'h708);
    chk("align_req", 32'(imem_req_o), 32'd1);
    chk("align_ready", 32'(pc_ready_o), 32'd0);

    // Fill to DEPTH with decode stalled.
    cyc(1, 32'h20, 1, 0, 32'h0,         0, 0);
    cyc(1, 32'h24, 1, 1, 32'hA000_0004, 0, 0);
    cyc(1, 32'h28, 1, 1, 32'hA000_0005, 0, 0);
    cyc(1, 32'h2C, 1, 1, 32'hA000_0006, 0, 0);
    cyc(1, 32'h30, 1, 1, 32'hA000_0007, 0, 0);
    chk("full_count", 32'(count_o), 32'd4);
    chk("full_req", 32'(imem_req_o), 32'd0);
    chk("full_ready", 32'(pc_ready_o), 32'd0);
    chk("full_head", dec_pc_o, 32'h20);
    cyc(1, 32'h30, 1, 0, 32'h0, 1, 0);
    chk("full_pop_same_cycle_req", 32'(imem_req_o), 32'd0);
    cyc(1, 32'h30, 1, 0, 32'h0, 0, 0);
    chk("full_after_pop_req", 32'(imem_req_o), 32'd1);
    chk("full_after_pop_ready", 32'(pc_ready_o), 32'd1);
    cyc(0, 32'h0, 0, 1, 32'hA000_0008, 1, 0);
    idle(4);
    chk("full_drained", 32'(count_o), 32'd0);

    // Flush with two outstanding fetches.
    cyc(1, 32'h40, 1, 0, 32'h0, 1, 0);
    cyc(1, 32'h44, 1, 0, 32'h0, 1, 0);
    cyc(0, 32'h0,  0, 0, 32'h0, 1, 1);
    cyc(0, 32'h0,  0, 1, 32'hDEAD_0000, 1, 0);
    chk("flush2_count", 32'(count_o), 32'd0);
    chk("flush2_dec_valid", 32'(dec_valid_o), 32'd0);
    cyc(0, 32'h0,  0, 1, 32'hDEAD_0001, 1, 0);
    cyc(1, 32'h100, 1, 0, 32'h0, 1, 0);
    chk("flush2_dropped_count", 32'(count_o), 32'd0);
    chk("flush2_dropped_valid", 32'(dec_valid_o), 32'd0);
    cyc(0, 32'h0, 0, 1, 32'hB000_0100, 1, 0);
    cyc(0, 32'h0, 0, 0, 32'h0, 1, 0);
    chk("flush2_new_valid", 32'(dec_valid_o), 32'd1);
    chk("flush2_new_pc", dec_pc_o, 32'h100);
    chk("flush2_new_instr", dec_instr_o, 32'hB000_0100);
    idle(1);

    // Flush coincident with a response, three outstanding.
    cyc(1, 32'h200, 1, 0, 32'h0, 0, 0);
    cyc(1, 32'h204, 1, 0, 32'h0, 0, 0);
    cyc(1, 32'h208, 1, 0, 32'h0, 0, 0);
    cyc(0, 32'h0,   0, 1, 32'hDEAD_0010, 0, 1);
    cyc(0, 32'h0,   0, 1, 32'hDEAD_0011, 0, 0);
    cyc(0, 32'h0,   0, 1, 32'hDEAD_0012, 0, 0);
    cyc(1, 32'h300, 1, 0, 32'h0, 0, 0);
    chk("flush3_count", 32'(count_o), 32'd0);
    cyc(0, 32'h0,   0, 1, 32'hC000_0300, 0, 0);
    chk("flush3_pending_count", 32'(count_o), 32'd1);
    chk("flush3_pending_valid", 32'(dec_valid_o), 32'd0);
    cyc(0, 32'h0,   0, 0, 32'h0, 1, 0);
    chk("flush3_new_valid", 32'(dec_valid_o), 32'd1);
    chk("flush3_new_pc", dec_pc_o, 32'h300);
    chk("flush3_new_instr", dec_instr_o, 32'hC000_0300);
    idle(1);

    // Allocate, fill and pop together at count 2.
    cyc(1, 32'h400, 1, 0, 32'h0,         0, 0);
    cyc(1, 32'h404, 1, 1, 32'hD000_0400, 0, 0);
    cyc(1, 32'h408, 1, 1, 32'hD000_0404, 1, 0);
    chk("simul_count_before", 32'(count_o), 32'd2);
    chk("simul_head_pc", dec_pc_o, 32'h400);
    chk("simul_head_instr", dec_instr_o, 32'hD000_0400);
    cyc(0, 32'h0, 0, 1, 32'hD000_0408, 1, 0);
    chk("simul_count_after", 32'(count_o), 32'd2);
    chk("simul_next_pc", dec_pc_o, 32'h404);
    chk("simul_next_instr", dec_instr_o, 32'hD000_0404);
    cyc(0, 32'h0, 0, 0, 32'h0, 1, 0);
    chk("simul_last_count", 32'(count_o), 32'd1);
    chk("simul_last_pc", dec_pc_o, 32'h408);
    chk("simul_last_instr", dec_instr_o, 32'hD000_0408);
    idle(1);

    // Asynchronous reset in the middle of a burst.
    cyc(1, 32'h500, 1, 0, 32'h0,         0, 0);
    cyc(1, 32'h504, 1, 1, 32'hE000_0500, 0, 0);
    cyc(1, 32'h508, 1, 1, 32'hE000_0504, 0, 0);
    chk("areset_pre_count", 32'(count_o), 32'd2);
    chk("areset_pre_valid", 32'(dec_valid_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("areset_dec_valid", 32'(dec_valid_o), 32'd0);
    chk("areset_req", 32'(imem_req_o), 32'd0);
    chk("areset_pc_ready", 32'(pc_ready_o), 32'd0);
    chk("areset_count", 32'(count_o), 32'd0);
    cyc(0, 32'h0, 0, 0, 32'h0, 0, 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    cyc(1, 32'h600, 1, 0, 32'h0,         1, 0);
    cyc(0, 32'h0,   0, 1, 32'hF000_0600, 1, 0);
    cyc(0, 32'h0,   0, 0, 32'h0,         1, 0);
    chk("post_reset_pc", dec_pc_o, 32'h600);
    chk("post_reset_instr", dec_instr_o, 32'hF000_0600);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
